// File: rtl/io_port_hub_pkg.sv
// Shared definitions for the I/O port hub: default sizes and address-width helper.
package io_port_hub_pkg;

  localparam int unsigned NUBITS_DEF = 16;
  localparam int unsigned NUIOIN_DEF = 2;
  localparam int unsigned NUIOOU_DEF = 2;
  localparam int unsigned ODEPTH_DEF = 4;

  // Select/pointer width; never narrower than one bit.
  function automatic int unsigned addr_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/io_port_hub_if.sv
// Processor I/O bus plus the per-port producer/consumer streams of the hub.
interface io_port_hub_if
  import io_port_hub_pkg::*;
#(
  parameter int unsigned NUBITS = NUBITS_DEF,
  parameter int unsigned NUIOIN = NUIOIN_DEF,
  parameter int unsigned NUIOOU = NUIOOU_DEF
);

  localparam int unsigned IAW = addr_w(NUIOIN);
  localparam int unsigned OAW = addr_w(NUIOOU);

  logic [NUBITS-1:0]        io_out;
  logic [OAW-1:0]           addr_out;
  logic                     out_en;
  logic [NUBITS-1:0]        io_in;
  logic [IAW-1:0]           addr_in;
  logic                     req_in;
  logic                     itr;
  logic [NUIOIN*NUBITS-1:0] in_data;
  logic [NUIOIN-1:0]        in_valid;
  logic [NUIOIN-1:0]        in_ready;
  logic [NUIOOU*NUBITS-1:0] out_data;
  logic [NUIOOU-1:0]        out_valid;
  logic [NUIOOU-1:0]        out_ready;
  logic [NUIOOU-1:0]        ovf;

  modport master (
    output io_out, addr_out, out_en, addr_in, req_in, in_data, in_valid, out_ready,
    input  io_in, itr, in_ready, out_data, out_valid, ovf
  );

  modport slave (
    input  io_out, addr_out, out_en, addr_in, req_in, in_data, in_valid, out_ready,
    output io_in, itr, in_ready, out_data, out_valid, ovf
  );

endinterface

// File: rtl/io_port_hub_fifo.sv
// Output-port FIFO: push while full without a pop drops the word and sets sticky ovf.
module io_fifo
  import io_port_hub_pkg::*;
#(
  parameter int unsigned NUBITS = NUBITS_DEF,
  parameter int unsigned ODEPTH = ODEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [NUBITS-1:0] din,
  output logic [NUBITS-1:0] dout,
  output logic              empty,
  output logic              full,
  output logic              ovf
);

  localparam int unsigned FAW = addr_w(ODEPTH);
  localparam int unsigned CW  = FAW + 1;

  logic [NUBITS-1:0] mem_q [ODEPTH];
  logic [FAW-1:0]    rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              push_eff, pop_eff;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CW'(ODEPTH));
  assign dout  = mem_q[rd_q];
  assign ovf   = ovf_q;

  // A pop frees the slot, so a push into a full FIFO still lands in the same cycle.
  assign pop_eff  = pop & ~empty;
  assign push_eff = push & (~full | pop_eff);

  always_comb begin
    rd_d  = pop_eff  ? rd_q + 1'b1 : rd_q;
    wr_d  = push_eff ? wr_q + 1'b1 : wr_q;
    cnt_d = cnt_q;
    case ({push_eff, pop_eff})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    ovf_d = ovf_q | (push & full & ~pop_eff);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q <= '{default: '0};
    end else if (push_eff) begin
      mem_q[wr_q] <= din;
    end
  end

endmodule

// File: rtl/io_port_hub.sv
// Peripheral-side I/O responder: input holding registers with read mux, per-port output FIFOs, interrupt.
module io_port_hub
  import io_port_hub_pkg::*;
#(
  parameter int unsigned NUBITS = NUBITS_DEF,
  parameter int unsigned NUIOIN = NUIOIN_DEF,
  parameter int unsigned NUIOOU = NUIOOU_DEF,
  parameter int unsigned ODEPTH = ODEPTH_DEF
) (
  input logic          clk,
  input logic          rst,
  io_port_hub_if.slave bus
);

  localparam int unsigned IAW = addr_w(NUIOIN);
  localparam int unsigned OAW = addr_w(NUIOOU);

  logic [NUBITS-1:0] hold_q [NUIOIN];
  logic [NUBITS-1:0] hold_d [NUIOIN];
  logic [NUIOIN-1:0] hv_q, hv_d;
  logic [NUBITS-1:0] io_in_q, io_in_d;
  logic              itr_q, itr_d;

  always_comb begin
    hold_d  = hold_q;
    hv_d    = hv_q;
    io_in_d = io_in_q;
    for (int unsigned k = 0; k < NUIOIN; k++) begin
      if (bus.req_in && (bus.addr_in == IAW'(k))) begin
        io_in_d = hold_q[k];
        hv_d[k] = 1'b0;
      end
    end
    // Capture is applied after the read so a word arriving on an empty port being read is kept.
    for (int unsigned k = 0; k < NUIOIN; k++) begin
      if (bus.in_valid[k] && !hv_q[k]) begin
        hold_d[k] = bus.in_data[k*NUBITS +: NUBITS];
        hv_d[k]   = 1'b1;
      end
    end
    itr_d = |hv_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_q  <= '{default: '0};
      hv_q    <= '0;
      io_in_q <= '0;
      itr_q   <= 1'b0;
    end else begin
      hold_q  <= hold_d;
      hv_q    <= hv_d;
      io_in_q <= io_in_d;
      itr_q   <= itr_d;
    end
  end

  assign bus.in_ready = ~hv_q;
  assign bus.io_in    = io_in_q;
  assign bus.itr      = itr_q;

  for (genvar j = 0; j < NUIOOU; j++) begin : g_out
    logic fifo_empty;

    io_fifo #(
      .NUBITS(NUBITS),
      .ODEPTH(ODEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (bus.out_en && (bus.addr_out == OAW'(j))),
      .pop   (bus.out_ready[j]),
      .din   (bus.io_out),
      .dout  (bus.out_data[j*NUBITS +: NUBITS]),
      .empty (fifo_empty),
      .full  (),
      .ovf   (bus.ovf[j])
    );

    assign bus.out_valid[j] = ~fifo_empty;
  end

endmodule

// File: tb/tb_io_port_hub.sv
// Bench for io_port_hub: input-side vector table, output-side scoreboard queues.
module tb_io_port_hub;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  logic [15:0] sbq0 [$];
  logic [15:0] sbq1 [$];
  logic [1:0]  exp_ovf = 2'b00;

  io_port_hub_if #(.NUBITS(16), .NUIOIN(2), .NUIOOU(2)) bus_if ();

  io_port_hub #(
    .NUBITS(16),
    .NUIOIN(2),
    .NUIOOU(2),
    .ODEPTH(4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [1:0]  vld;
    logic [15:0] d0;
    logic [15:0] d1;
    logic        req;
    logic        addr;
    logic [15:0] e_io;
    logic        e_itr;
    logic [1:0]  e_rdy;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_push(input int p, input logic [15:0] d);
    if (p == 0) sbq0.push_back(d);
    else        sbq1.push_back(d);
  endtask

  task automatic sb_pop(input int p, output logic [15:0] d, output bit ok);
    ok = 1'b1;
    d  = '0;
    if (p == 0) begin
      if (sbq0.size() == 0) ok = 1'b0; else d = sbq0.pop_front();
    end else begin
      if (sbq1.size() == 0) ok = 1'b0; else d = sbq1.pop_front();
    end
  endtask

  function automatic int sb_size(input int p);
    return (p == 0) ? sbq0.size() : sbq1.size();
  endfunction

  // Single write strobe with the consumer of that port stalled.
  task automatic wr(input int p, input logic [15:0] d);
    bus_if.out_en   = 1'b1;
    bus_if.addr_out = p[0];
    bus_if.io_out   = d;
    if (sb_size(p) == 4) exp_ovf[p] = 1'b1;
    else                 sb_push(p, d);
    tick();
    bus_if.out_en = 1'b0;
    chk("ovf_after_write", {30'd0, bus_if.ovf}, {30'd0, exp_ovf});
  endtask

  task automatic drain(input int p);
    logic [15:0] e;
    bit          ok;
    bus_if.out_ready[p] = 1'b1;
    for (int c = 0; c < 16; c++) begin
      if (!bus_if.out_valid[p]) break;
      sb_pop(p, e, ok);
      chk("drain_expected_word", {31'd0, ok}, 32'd1);
      chk("drain_data", {16'd0, bus_if.out_data[p*16 +: 16]}, {16'd0, e});
      tick();
    end
    bus_if.out_ready[p] = 1'b0;
    chk("drain_valid_low", {31'd0, bus_if.out_valid[p]}, 32'd0);
    chk("drain_sb_empty", sb_size(p), 32'd0);
  endtask

  initial begin
    vecs[0]  = '{2'b10, 16'h0000, 16'h00A5, 1'b0, 1'b0, 16'h0000, 1'b1, 2'b01};
    vecs[1]  = '{2'b00, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 2'b01};
    vecs[2]  = '{2'b00, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h00A5, 1'b0, 2'b11};
    vecs[3]  = '{2'b00, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h00A5, 1'b0, 2'b11};
    vecs[4]  = '{2'b11, 16'h1234, 16'hBEEF, 1'b0, 1'b0, 16'h00A5, 1'b1, 2'b00};
    vecs[5]  = '{2'b00, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h1234, 1'b1, 2'b01};
    vecs[6]  = '{2'b00, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'hBEEF, 1'b0, 2'b11};
    vecs[7]  = '{2'b00, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'hBEEF, 1'b0, 2'b11};
    vecs[8]  = '{2'b01, 16'h1111, 16'h0000, 1'b0, 1'b0, 16'hBEEF, 1'b1, 2'b10};
    vecs[9]  = '{2'b01, 16'h2222, 16'h0000, 1'b1, 1'b0, 16'h1111, 1'b0, 2'b11};
    vecs[10] = '{2'b01, 16'h2222, 16'h0000, 1'b0, 1'b0, 16'h1111, 1'b1, 2'b10};
    vecs[11] = '{2'b00, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'h2222, 1'b0, 2'b11};
    vecs[12] = '{2'b10, 16'h0000, 16'h3333, 1'b1, 1'b0, 16'h2222, 1'b1, 2'b01};
    vecs[13] = '{2'b00, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h3333, 1'b0, 2'b11};

    bus_if.io_out    = '0;
    bus_if.addr_out  = '0;
    bus_if.out_en    = 1'b0;
    bus_if.addr_in   = '0;
    bus_if.req_in    = 1'b0;
    bus_if.in_data   = '0;
    bus_if.in_valid  = '0;
    bus_if.out_ready = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk("reset_in_ready",  {30'd0, bus_if.in_ready},  32'h3);
    chk("reset_out_valid", {30'd0, bus_if.out_valid}, 32'h0);
    chk("reset_itr",       {31'd0, bus_if.itr},       32'h0);
    chk("reset_io_in",     {16'd0, bus_if.io_in},     32'h0);
    chk("reset_ovf",       {30'd0, bus_if.ovf},       32'h0);
    chk("reset_out_data",  bus_if.out_data,           32'h0);

    for (int i = 0; i < 14; i++) begin
      bus_if.in_valid = vecs[i].vld;
      bus_if.in_data  = {vecs[i].d1, vecs[i].d0};
      bus_if.req_in   = vecs[i].req;
      bus_if.addr_in  = vecs[i].addr;
      tick();
      chk($sformatf("vec%0d_io_in", i),    {16'd0, bus_if.io_in},    {16'd0, vecs[i].e_io});
      chk($sformatf("vec%0d_itr", i),      {31'd0, bus_if.itr},      {31'd0, vecs[i].e_itr});
      chk($sformatf("vec%0d_in_ready", i), {30'd0, bus_if.in_ready}, {30'd0, vecs[i].e_rdy});
    end
    bus_if.in_valid = '0;
    bus_if.req_in   = 1'b0;

    // FIFO order on port 0.
    for (int i = 1; i <= 4; i++) wr(0, 16'(i));
    chk("fifo0_valid_full", {31'd0, bus_if.out_valid[0]}, 32'd1);
    chk("fifo0_head",       {16'd0, bus_if.out_data[15:0]}, 32'd1);
    drain(0);

    // Overflow on port 1: fifth word dropped, flag sticks through drain.
    for (int i = 0; i < 5; i++) wr(1, 16'h0100 + 16'(i));
    chk("ovf1_set", {31'd0, bus_if.ovf[1]}, 32'd1);
    drain(1);
    chk("ovf1_sticky", {31'd0, bus_if.ovf[1]}, 32'd1);
    chk("ovf0_clear",  {31'd0, bus_if.ovf[0]}, 32'd0);

    // Push and pop on a full FIFO in the same cycle.
    for (int i = 0; i < 4; i++) wr(0, 16'h0010 + 16'(i));
    begin
      logic [15:0] e;
      bit          ok;
      bus_if.out_ready[0] = 1'b1;
      bus_if.out_en       = 1'b1;
      bus_if.addr_out     = 1'b0;
      bus_if.io_out       = 16'h0077;
      sb_pop(0, e, ok);
      chk("fullpp_head", {16'd0, bus_if.out_data[15:0]}, {16'd0, e});
      sb_push(0, 16'h0077);
      tick();
      bus_if.out_en = 1'b0;
      chk("fullpp_ovf0", {31'd0, bus_if.ovf[0]}, 32'd0);
      drain(0);
      chk("fullpp_ovf0_after", {31'd0, bus_if.ovf[0]}, 32'd0);
    end

    // Asynchronous reset with queued and held data.
    wr(0, 16'h00AA);
    wr(0, 16'h00BB);
    bus_if.in_valid = 2'b01;
    bus_if.in_data  = {16'h0000, 16'hCCCC};
    tick();
    bus_if.in_valid = '0;
    chk("pre_rst_itr",      {31'd0, bus_if.itr},      32'd1);
    chk("pre_rst_in_ready", {30'd0, bus_if.in_ready}, 32'h2);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_out_valid", {30'd0, bus_if.out_valid}, 32'h0);
    chk("async_rst_itr",       {31'd0, bus_if.itr},       32'h0);
    chk("async_rst_in_ready",  {30'd0, bus_if.in_ready},  32'h3);
    chk("async_rst_ovf",       {30'd0, bus_if.ovf},       32'h0);
    chk("async_rst_io_in",     {16'd0, bus_if.io_in},     32'h0);
    sbq0.delete();
    sbq1.delete();
    exp_ovf = 2'b00;
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk("post_rst_out_valid", {30'd0, bus_if.out_valid}, 32'h0);
    wr(1, 16'h0042);
    drain(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
